// File: rtl/scan_sequencer.sv
// scan_sequencer: programs AFE gain/offset over 3-wire serial, then runs CCD integrate/transfer/readout lines.
// Optional build macro SCAN_RECONFIG_EN: reprogram the AFE between lines when gain/offset inputs change.
module scan_sequencer #(
    parameter int unsigned SPI_DIV     = 4,
    parameter int unsigned INT_CYCLES  = 10000,
    parameter int unsigned SH_CYCLES   = 8,
    parameter int unsigned PIX_DIV     = 4,
    parameter int unsigned LINE_PIXELS = 2048,
    parameter int unsigned NUM_LINES   = 4096
) (
    input  logic        clk_100M,
    input  logic        nrst,
    input  logic        cont_en,
    input  logic [15:0] cont_gain,
    input  logic [15:0] cont_off,
    input  logic        line_rdy,
    output logic        afe_sclk,
    output logic        afe_sdata,
    output logic        afe_sload,
    output logic        ccd_sh,
    output logic        pix_valid,
    output logic        line_start,
    output logic [15:0] line_cnt,
    output logic        scan_busy,
    output logic        scan_done
);
    localparam int unsigned CNT_MAX   = (INT_CYCLES > SH_CYCLES) ? INT_CYCLES : SH_CYCLES;
    localparam int unsigned CW        = $clog2(CNT_MAX) + 1;
    localparam int unsigned SDW       = $clog2(SPI_DIV) + 1;
    localparam int unsigned PDW       = $clog2(PIX_DIV) + 1;
    localparam int unsigned PCW       = $clog2(LINE_PIXELS + 1) + 1;
    localparam logic [15:0] LAST_LINE = 16'(NUM_LINES);

    typedef enum logic [2:0] {
        IDLE, CFG_GAIN, CFG_OFF, INTEGRATE, SH, READOUT, WAIT_RDY, DONE
    } state_t;

    state_t         state;
    logic           en_q, en_prev;
    logic [15:0]    gain_sh, off_sh;
    logic [CW-1:0]  cnt;
    logic [SDW-1:0] spi_div_cnt;
    logic [5:0]     half_cnt;
    logic [23:0]    shreg;
    logic [PDW-1:0] pix_div_cnt;
    logic [PCW-1:0] pix_cnt;

    logic           spi_div_last, frame_end, last_line;
    logic [5:0]     half_next;
    logic [15:0]    line_cnt_next;
    logic [23:0]    start_frame, gain_frame, off_frame;

`ifdef SCAN_RECONFIG_EN
    logic           reconfig_pend;
    logic           cfg_changed;
    assign cfg_changed = (gain_sh != cont_gain) || (off_sh != cont_off);
`endif

    // Frame timeline in half-bit steps: halves 0..47 carry 24 bits (even=sclk low), half 48 is the gap.
    always_comb begin
        spi_div_last  = (spi_div_cnt == SDW'(SPI_DIV - 1));
        half_next     = spi_div_last ? half_cnt + 6'd1 : half_cnt;
        frame_end     = spi_div_last && (half_cnt == 6'd48);
        line_cnt_next = line_cnt + 16'd1;
        last_line     = (NUM_LINES != 0) && (line_cnt_next == LAST_LINE);
        start_frame   = {8'h01, cont_gain};
        gain_frame    = {8'h01, gain_sh};
        off_frame     = {8'h02, off_sh};
    end

    always_ff @(posedge clk_100M or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            en_q        <= 1'b1;   // seeded high so a level-high enable out of reset is not an edge
            en_prev     <= 1'b1;
            gain_sh     <= '0;
            off_sh      <= '0;
            cnt         <= '0;
            spi_div_cnt <= '0;
            half_cnt    <= '0;
            shreg       <= '0;
            pix_div_cnt <= '0;
            pix_cnt     <= '0;
            afe_sclk    <= 1'b0;
            afe_sdata   <= 1'b0;
            afe_sload   <= 1'b1;
            ccd_sh      <= 1'b0;
            pix_valid   <= 1'b0;
            line_start  <= 1'b0;
            line_cnt    <= '0;
            scan_busy   <= 1'b0;
            scan_done   <= 1'b0;
`ifdef SCAN_RECONFIG_EN
            reconfig_pend <= 1'b0;
`endif
        end else begin
            en_q       <= cont_en;
            en_prev    <= en_q;
            pix_valid  <= 1'b0;
            line_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (en_q && !en_prev) begin
                        gain_sh     <= cont_gain;
                        off_sh      <= cont_off;
                        line_cnt    <= '0;
                        scan_busy   <= 1'b1;
                        state       <= CFG_GAIN;
                        afe_sload   <= 1'b0;
                        afe_sclk    <= 1'b0;
                        afe_sdata   <= start_frame[23];
                        shreg       <= {start_frame[22:0], 1'b0};
                        spi_div_cnt <= '0;
                        half_cnt    <= '0;
`ifdef SCAN_RECONFIG_EN
                        reconfig_pend <= 1'b0;
`endif
                    end
                end
                CFG_GAIN, CFG_OFF: begin
                    if (frame_end) begin
                        if (!en_q) begin
                            state     <= IDLE;
                            scan_busy <= 1'b0;
                        end else if (state == CFG_GAIN) begin
                            state       <= CFG_OFF;
                            afe_sload   <= 1'b0;
                            afe_sclk    <= 1'b0;
                            afe_sdata   <= off_frame[23];
                            shreg       <= {off_frame[22:0], 1'b0};
                            spi_div_cnt <= '0;
                            half_cnt    <= '0;
                        end else begin
                            state <= INTEGRATE;
                            cnt   <= '0;
                        end
                    end else begin
                        spi_div_cnt <= spi_div_last ? '0 : spi_div_cnt + 1'b1;
                        half_cnt    <= half_next;
                        afe_sclk    <= half_next[0];
                        afe_sload   <= (half_next == 6'd48);
                        if (spi_div_last && !half_next[0]) begin
                            if (half_next == 6'd48) begin
                                afe_sdata <= 1'b0;
                            end else begin
                                afe_sdata <= shreg[23];
                                shreg     <= {shreg[22:0], 1'b0};
                            end
                        end
                    end
                end
                INTEGRATE: begin
                    if (!en_q) begin
                        state     <= IDLE;
                        scan_busy <= 1'b0;
                    end else if (cnt == CW'(INT_CYCLES - 1)) begin
                        state  <= SH;
                        ccd_sh <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SH: begin
                    if (!en_q) begin
                        state     <= IDLE;
                        scan_busy <= 1'b0;
                        ccd_sh    <= 1'b0;
                    end else if (cnt == CW'(SH_CYCLES - 1)) begin
                        state       <= READOUT;
                        ccd_sh      <= 1'b0;
                        pix_valid   <= 1'b1;
                        line_start  <= 1'b1;
                        pix_cnt     <= PCW'(1);
                        pix_div_cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READOUT: begin
                    if (pix_div_cnt == PDW'(PIX_DIV - 1)) begin
                        pix_div_cnt <= '0;
                        if (pix_cnt == PCW'(LINE_PIXELS)) begin
                            // Line always completes; cont_en is only honoured at the line boundary.
                            line_cnt <= line_cnt_next;
                            if (last_line) begin
                                state     <= DONE;
                                scan_busy <= 1'b0;
                                scan_done <= 1'b1;
                            end else if (!en_q) begin
                                state     <= IDLE;
                                scan_busy <= 1'b0;
                            end else begin
                                state <= WAIT_RDY;
`ifdef SCAN_RECONFIG_EN
                                if (cfg_changed) begin
                                    gain_sh       <= cont_gain;
                                    off_sh        <= cont_off;
                                    reconfig_pend <= 1'b1;
                                end
`endif
                            end
                        end else begin
                            pix_valid <= 1'b1;
                            pix_cnt   <= pix_cnt + 1'b1;
                        end
                    end else begin
                        pix_div_cnt <= pix_div_cnt + 1'b1;
                    end
                end
                WAIT_RDY: begin
                    if (!en_q) begin
                        state     <= IDLE;
                        scan_busy <= 1'b0;
                    end else if (line_rdy) begin
`ifdef SCAN_RECONFIG_EN
                        if (reconfig_pend) begin
                            reconfig_pend <= 1'b0;
                            state         <= CFG_GAIN;
                            afe_sload     <= 1'b0;
                            afe_sclk      <= 1'b0;
                            afe_sdata     <= gain_frame[23];
                            shreg         <= {gain_frame[22:0], 1'b0};
                            spi_div_cnt   <= '0;
                            half_cnt      <= '0;
                        end else begin
                            state <= INTEGRATE;
                            cnt   <= '0;
                        end
`else
                        state <= INTEGRATE;
                        cnt   <= '0;
`endif
                    end
                end
                DONE: begin
                    if (!en_q) begin
                        state     <= IDLE;
                        scan_done <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: table-driven scans checked against an event-timeline model, plus corner sequences.
module tb_scan_sequencer;
    localparam int unsigned D    = 2;
    localparam int unsigned INTC = 20;
    localparam int unsigned SHC  = 3;
    localparam int unsigned PD   = 2;
    localparam int unsigned NP   = 8;
    localparam int unsigned NL   = 3;
    localparam int          LP   = INTC + SHC + NP * PD + 1;

    logic        clk_100M = 1'b0;
    logic        nrst     = 1'b1;
    logic        cont_en  = 1'b1;
    logic [15:0] cont_gain = 16'h0000;
    logic [15:0] cont_off  = 16'h0000;
    logic        line_rdy  = 1'b1;
    logic        afe_sclk, afe_sdata, afe_sload, ccd_sh, pix_valid, line_start, scan_busy, scan_done;
    logic [15:0] line_cnt;

    scan_sequencer #(
        .SPI_DIV(D), .INT_CYCLES(INTC), .SH_CYCLES(SHC),
        .PIX_DIV(PD), .LINE_PIXELS(NP), .NUM_LINES(NL)
    ) dut (
        .clk_100M(clk_100M), .nrst(nrst), .cont_en(cont_en), .cont_gain(cont_gain),
        .cont_off(cont_off), .line_rdy(line_rdy), .afe_sclk(afe_sclk), .afe_sdata(afe_sdata),
        .afe_sload(afe_sload), .ccd_sh(ccd_sh), .pix_valid(pix_valid), .line_start(line_start),
        .line_cnt(line_cnt), .scan_busy(scan_busy), .scan_done(scan_done)
    );

    always #5 clk_100M = ~clk_100M;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk_100M) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    // Event logs, sampled on the falling edge
    int   q_pix[$], q_ls[$], q_sh[$], q_fall[$], q_rise[$], q_done[$];
    bit   q_bit[$];
    logic p_sload = 1'b1, p_sclk = 1'b0, p_sh = 1'b0, p_done = 1'b0;
    int   rdy_mode  = 0;
    int   stall_cnt = 0;
    bit   rdy_drv [65536];

    always @(negedge clk_100M) begin
        if (pix_valid) q_pix.push_back(cyc);
        if (line_start) q_ls.push_back(cyc);
        if (ccd_sh && !p_sh) q_sh.push_back(cyc);
        if (!afe_sload && p_sload) q_fall.push_back(cyc);
        if (afe_sload && !p_sload) q_rise.push_back(cyc);
        if (afe_sclk && !p_sclk) q_bit.push_back(afe_sdata);
        if (scan_done && !p_done) q_done.push_back(cyc);
        p_sload = afe_sload;
        p_sclk  = afe_sclk;
        p_sh    = ccd_sh;
        p_done  = scan_done;
        case (rdy_mode)
            0: line_rdy = 1'b1;
            1: line_rdy = ($urandom_range(0, 3) == 0);
            default: begin
                if (line_cnt == 16'd1 && stall_cnt < 50) begin
                    line_rdy = 1'b0;
                    stall_cnt++;
                end else begin
                    line_rdy = 1'b1;
                end
            end
        endcase
        if (cyc < 65536) rdy_drv[cyc] = line_rdy;
    end

    task automatic clear_logs();
        q_pix.delete(); q_ls.delete(); q_sh.delete(); q_fall.delete();
        q_rise.delete(); q_done.delete(); q_bit.delete();
        stall_cnt = 0;
    endtask

    task automatic wait_until_cyc(input int c);
        while (cyc < c) @(negedge clk_100M);
    endtask

    function automatic logic [23:0] word_at(input int base);
        logic [23:0] w = '0;
        for (int i = 0; i < 24; i++)
            if (base + i < q_bit.size()) w = {w[22:0], q_bit[base + i]};
        return w;
    endfunction

    task automatic wait_done();
        for (int i = 0; i < 20000 && !scan_done; i++) @(negedge clk_100M);
        chk("done_timeout", scan_done, 1);
    endtask

    // Expected timeline: start edge at cycle s, two frames of 49*D, then per line INT+SH+NP*PD,
    // next line integrating the cycle after the first sampled line_rdy=1 in WAIT_RDY.
    task automatic check_timeline(input int s);
        int i0, r0, e, c, idx;
        chk("n_pix", q_pix.size(), NL * NP);
        chk("n_line_start", q_ls.size(), NL);
        chk("n_sh", q_sh.size(), NL);
        chk("n_frames", q_fall.size(), 2);
        if (q_fall.size() >= 2 && q_rise.size() >= 2) begin
            chk("gain_fall", q_fall[0], s + 2);
            chk("off_fall", q_fall[1], s + 2 + 49 * D);
            chk("gain_low_len", q_rise[0] - q_fall[0], 48 * D);
            chk("off_low_len", q_rise[1] - q_fall[1], 48 * D);
        end
        i0 = s + 2 + 98 * D;
        for (int l = 0; l < NL; l++) begin
            if (l < q_sh.size()) chk("sh_rise", q_sh[l], i0 + INTC);
            r0 = i0 + INTC + SHC;
            if (l < q_ls.size()) chk("line_start", q_ls[l], r0);
            for (int k = 0; k < NP; k++) begin
                idx = l * NP + k;
                if (idx < q_pix.size()) chk("pix", q_pix[idx], r0 + k * PD);
            end
            e = r0 + NP * PD;
            if (l == NL - 1) begin
                if (q_done.size() > 0) chk("done_at", q_done[0], e);
            end else begin
                c = e;
                while (c < e + 5000 && !rdy_drv[c]) c++;
                i0 = c + 1;
            end
        end
    endtask

    typedef struct {
        logic [15:0] gain;
        logic [15:0] off;
        int          mode;
        logic [23:0] w_gain;
        logic [23:0] w_off;
        logic [15:0] lines;
    } vec_t;

    vec_t tv[4];

    initial begin
        int s, n, b, e, cnt_f, exp_f, exp_sh;
        tv[0] = '{16'hA55A, 16'h0123, 0, 24'h01A55A, 24'h020123, 16'd3};
        tv[1] = '{16'hFFFF, 16'h0000, 1, 24'h01FFFF, 24'h020000, 16'd3};
        tv[2] = '{16'h0001, 16'h8000, 2, 24'h010001, 24'h028000, 16'd3};
        tv[3] = '{16'h5AA5, 16'h7E81, 1, 24'h015AA5, 24'h027E81, 16'd3};

        // Reset values, with cont_en already high
        #1 nrst = 1'b0;
        #1;
        chk("rst_sclk", afe_sclk, 0);   chk("rst_sdata", afe_sdata, 0);
        chk("rst_sload", afe_sload, 1); chk("rst_sh", ccd_sh, 0);
        chk("rst_pix", pix_valid, 0);   chk("rst_ls", line_start, 0);
        chk("rst_cnt", line_cnt, 0);    chk("rst_busy", scan_busy, 0);
        chk("rst_done", scan_done, 0);
        repeat (3) @(negedge clk_100M);
        nrst = 1'b1;
        clear_logs();
        repeat (30) @(negedge clk_100M);
        chk("level_no_start_frames", q_fall.size(), 0);
        chk("level_no_start_busy", scan_busy, 0);
        cont_en = 1'b0;
        repeat (3) @(negedge clk_100M);

        foreach (tv[v]) begin
            clear_logs();
            rdy_mode  = tv[v].mode;
            cont_gain = tv[v].gain;
            cont_off  = tv[v].off;
            @(negedge clk_100M);
            s = cyc;
            cont_en = 1'b1;
            wait_done();
            check_timeline(s);
            chk("n_bits", q_bit.size(), 48);
            chk("gain_word", word_at(0), tv[v].w_gain);
            chk("off_word", word_at(24), tv[v].w_off);
            chk("line_cnt_final", line_cnt, tv[v].lines);
            chk("busy_in_done", scan_busy, 0);
            repeat (5) @(negedge clk_100M);
            chk("done_held", scan_done, 1);
            cont_en = 1'b0;
            @(negedge clk_100M);
            chk("done_after_1", scan_done, 1);
            @(negedge clk_100M);
            chk("done_after_2", scan_done, 0);
            chk("line_cnt_held", line_cnt, tv[v].lines);
            repeat (3) @(negedge clk_100M);
        end

        // cont_en dropped mid-readout of line 2: line completes and is counted
        rdy_mode = 0;
        clear_logs();
        @(negedge clk_100M);
        s = cyc;
        cont_en = 1'b1;
        for (int i = 0; i < 2000 && q_ls.size() < 2; i++) @(negedge clk_100M);
        chk("c_reached_line2", q_ls.size(), 2);
        repeat (3) @(negedge clk_100M);
        cont_en = 1'b0;
        for (int i = 0; i < 2000 && scan_busy; i++) @(negedge clk_100M);
        b = cyc;
        e = s + 2 + 98 * D + LP + INTC + SHC + NP * PD;
        chk("c_busy_fall", b, e);
        chk("c_line_cnt", line_cnt, 2);
        chk("c_done", scan_done, 0);
        chk("c_pix", q_pix.size(), 2 * NP);
        repeat (3) @(negedge clk_100M);

        // cont_en dropped in first SH cycle: ccd_sh falls early
        @(negedge clk_100M);
        s = cyc;
        cont_en = 1'b1;
        n = s + 2 + 98 * D + INTC;
        wait_until_cyc(n);
        chk("d_sh_on", ccd_sh, 1);
        cont_en = 1'b0;
        @(negedge clk_100M);
        chk("d_sh_n1", ccd_sh, 1);
        chk("d_busy_n1", scan_busy, 1);
        @(negedge clk_100M);
        chk("d_sh_n2", ccd_sh, 0);
        chk("d_busy_n2", scan_busy, 0);
        repeat (3) @(negedge clk_100M);

        // Asynchronous reset mid SPI frame
        @(negedge clk_100M);
        s = cyc;
        cont_en = 1'b1;
        wait_until_cyc(s + 20);
        chk("e_in_frame", afe_sload, 0);
        #2 nrst = 1'b0;
        #1;
        chk("e_sload", afe_sload, 1); chk("e_sclk", afe_sclk, 0);
        chk("e_sdata", afe_sdata, 0); chk("e_busy", scan_busy, 0);
        chk("e_cnt", line_cnt, 0);
        @(negedge clk_100M);
        nrst = 1'b1;
        clear_logs();
        repeat (30) @(negedge clk_100M);
        chk("e_no_restart", q_fall.size(), 0);
        chk("e_idle", scan_busy, 0);
        cont_en = 1'b0;
        repeat (3) @(negedge clk_100M);
        clear_logs();
        s = cyc;
        cont_en = 1'b1;
        wait_until_cyc(s + 10);
        cont_en = 1'b0;
        wait_until_cyc(s + 1 + 49 * D);
        chk("e_frame_finishing", scan_busy, 1);
        @(negedge clk_100M);
        chk("e_idle_after_gap", scan_busy, 0);
        chk("e_one_frame", q_fall.size(), 1);
        if (q_fall.size() > 0) chk("e_restart_fall", q_fall[0], s + 2);
        repeat (3) @(negedge clk_100M);

        // Gain change during line 1
        clear_logs();
        rdy_mode  = 0;
        cont_gain = 16'hA55A;
        cont_off  = 16'h0123;
        @(negedge clk_100M);
        s = cyc;
        cont_en = 1'b1;
        for (int i = 0; i < 2000 && q_ls.size() < 1; i++) @(negedge clk_100M);
        cont_gain = 16'h1234;
        wait_done();
        e = s + 2 + 98 * D + INTC + SHC + NP * PD;
        cnt_f = 0;
        foreach (q_fall[i]) if (q_fall[i] >= e && q_sh.size() > 1 && q_fall[i] < q_sh[1]) cnt_f++;
`ifdef SCAN_RECONFIG_EN
        exp_f  = 2;
        exp_sh = e + 1 + 98 * D + INTC;
        chk("f_new_gain_word", word_at(48), 24'h011234);
        chk("f_off_word", word_at(72), 24'h020123);
`else
        exp_f  = 0;
        exp_sh = e + 1 + INTC;
`endif
        chk("f_frames_between", cnt_f, exp_f);
        if (q_sh.size() > 1) chk("f_sh_line2", q_sh[1], exp_sh);
        chk("f_line_cnt", line_cnt, 3);
        cont_en = 1'b0;
        repeat (3) @(negedge clk_100M);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        bad++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
